radix4_chunk_add_ctrl: RTL and testbench
========================================

Name: radix4_chunk_add_ctrl

Overview:
Sequencer that time-multiplexes one radix4adder_new instance (4-digit redundant radix-4 adder) to add two wide operands of NUM_CHUNKS chunks.
- Processes one 4-digit chunk per cycle, least-significant chunk first.
- Registers each chunk's cout and feeds it back as the next chunk's cin.
- Assembles the full-width result.
- Sits between the operand source (online-arithmetic pipeline, or a bench reading operand files) and downstream result consumers.

Parameters:
NUM_CHUNKS, 2, number of 4-digit chunks per operand (>=1)
NO_OF_DIGITS, 4, digits per chunk (matches adder instance)
RADIX_BITS, 3, bits per signed digit (two's complement)
RADIX, 4, radix of digit system

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request to begin an addition; accepted only when ready=1
cin  input  RADIX_BITS  signed carry-in into chunk 0, sampled with start
din1  input  NUM_CHUNKS*NO_OF_DIGITS*RADIX_BITS  operand A, sampled with start
din2  input  NUM_CHUNKS*NO_OF_DIGITS*RADIX_BITS  operand B, sampled with start
ready  output  1  high in IDLE and DONE
busy  output  1  high in RUN
done  output  1  one-cycle pulse when result is valid
chunk_idx  output  clog2(NUM_CHUNKS)+1  chunk currently in the adder (debug)
dout  output  NUM_CHUNKS*NO_OF_DIGITS*RADIX_BITS  assembled sum, held until next accepted start
cout  output  RADIX_BITS  carry out of the final chunk, held with dout

Behaviour:
- Chunk k occupies bits [(k+1)*CHUNK_W-1 : k*CHUNK_W], where CHUNK_W = NO_OF_DIGITS*RADIX_BITS. Chunk 0 is least significant.
- FSM states:
  - IDLE: ready=1. Start moves to RUN.
  - RUN: busy=1. Lasts exactly NUM_CHUNKS cycles, then moves to DONE.
  - DONE: ready=1, done=1 for this single cycle. Next state is IDLE, or RUN if start=1.
- On start accepted:
  - Capture din1, din2 into operand registers.
  - carry_reg <= cin; chunk_idx <= 0.
  - Clear dout and cout.
- Each RUN cycle:
  - Adder inputs = operand chunk[chunk_idx] plus carry_reg; the adder is combinational.
  - At the clock edge, dout chunk[chunk_idx] <= adder dout, carry_reg <= adder cout, chunk_idx increments.
  - On the last chunk, cout <= adder cout and the FSM moves to DONE.
- Latency: start sampled in cycle 0, done high in cycle NUM_CHUNKS+1.
- Throughput: one addition per NUM_CHUNKS+1 cycles; back-to-back operation is achieved by asserting start during DONE.
- start while busy is ignored (no queueing). din1, din2 and cin may change freely after acceptance.
- Correctness rule: value(dout) + value(cout)*RADIX^(NUM_CHUNKS*NO_OF_DIGITS) = value(din1) + value(din2) + value(cin). The digit encoding of dout is whatever the adder produces (redundant form).
- Reset (rst=1 in any state, including mid-RUN):
  - Next cycle: IDLE, ready=1, busy=0, done=0.
  - dout=0, cout=0, chunk_idx=0, carry_reg=0.
  - The partial result is discarded.
- NUM_CHUNKS=1: RUN lasts one cycle, and the result equals a single adder pass.

Optional Feature:
Macro RADIX4_CHUNK_CTRL_ACCUM_EN.
- Defined:
  - Extra input port acc (1 bit), sampled with start.
  - If acc=1, operand A is the current dout register instead of din1 (running accumulate: dout += din2).
  - cout from the accumulate pass replaces the previous cout.
  - acc is ignored on the first start after reset, since dout=0 and the result therefore equals din2+cin.
- Undefined: port absent; operand A is always din1.

Decomposition:
- Package radix4_pkg holds:
  - NO_OF_DIGITS, RADIX_BITS, RADIX defaults
  - CHUNK_W localparam
  - FSM state enum (IDLE, RUN, DONE)
  - digit-value helper function for bench checking
- Sub-module: one instance of the existing radix4adder_new #(NO_OF_DIGITS, RADIX_BITS, RADIX).
- Chunk select, carry register, result assembly and FSM stay in this module.

Test Plan:
- NUM_CHUNKS=2, din1=24'h249249 (all digits 1), din2=0, cin=0 -> done at cycle 3; value(dout)=value(din1); value(cout)=0.
- din1 = all digits 3 (value 4^8-1), din2=1, cin=0 -> value(dout) + value(cout)*4^8 = 4^8. Confirms inter-chunk carry through carry_reg.
- Start held high continuously with new operands each time -> accepted in cycles 0, 3, 6. Starts in RUN cycles are ignored; each done matches its own operands.
- rst asserted in cycle 1 of RUN -> next cycle IDLE, dout=0, cout=0, done never pulses. A subsequent start completes normally.
- cin = -1 (3'b111), din1=din2=0 -> value(dout) + cout term = -1.
- With RADIX4_CHUNK_CTRL_ACCUM_EN: three starts with acc=1, din2 = value 5 each -> final value(dout)=15.

Source files
------------

// File: rtl/radix4_pkg.sv
// Shared constants, FSM state type and a digit-value helper for the chunked radix-4 adder.
package radix4_pkg;

  localparam int NO_OF_DIGITS_DEF = 4;
  localparam int RADIX_BITS_DEF   = 3;
  localparam int RADIX_DEF        = 4;
  localparam int CHUNK_W          = NO_OF_DIGITS_DEF * RADIX_BITS_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Numeric value of a vector of signed two's-complement digits, digit 0 least significant.
  function automatic longint digits_value(input logic [63:0] v, input int ndig, input int rbits);
    longint acc;
    longint w;
    longint u;
    acc = 0;
    w   = 1;
    for (int i = 0; i < ndig; i++) begin
      u = longint'((v >> (i * rbits)) & ((64'd1 << rbits) - 64'd1));
      if (u >= (longint'(1) << (rbits - 1))) u = u - (longint'(1) << rbits);
      acc = acc + u * w;
      w   = w * RADIX_DEF;
    end
    return acc;
  endfunction

endpackage

// File: rtl/radix4adder_new.sv
// Combinational redundant radix-4 adder: signed-digit inputs, digits out in [0, RADIX-1],
// signed carry rippled digit to digit. Assumes RADIX is a power of two.
module radix4adder_new
  import radix4_pkg::*;
#(
  parameter int NO_OF_DIGITS = NO_OF_DIGITS_DEF,
  parameter int RADIX_BITS   = RADIX_BITS_DEF,
  parameter int RADIX        = RADIX_DEF
) (
  input  logic [NO_OF_DIGITS*RADIX_BITS-1:0] a,
  input  logic [NO_OF_DIGITS*RADIX_BITS-1:0] b,
  input  logic [RADIX_BITS-1:0]              cin,
  output logic [NO_OF_DIGITS*RADIX_BITS-1:0] sum,
  output logic [RADIX_BITS-1:0]              cout
);

  localparam int LR = $clog2(RADIX);
  localparam int TW = RADIX_BITS + LR;

  logic [RADIX_BITS-1:0] carry [NO_OF_DIGITS+1];

  assign carry[0] = cin;

  for (genvar i = 0; i < NO_OF_DIGITS; i++) begin : g_dig
    logic [RADIX_BITS-1:0] da, db;
    logic [TW-1:0]         t;
    assign da = a[i*RADIX_BITS +: RADIX_BITS];
    assign db = b[i*RADIX_BITS +: RADIX_BITS];
    assign t  = {{(TW-RADIX_BITS){da[RADIX_BITS-1]}}, da}
              + {{(TW-RADIX_BITS){db[RADIX_BITS-1]}}, db}
              + {{(TW-RADIX_BITS){carry[i][RADIX_BITS-1]}}, carry[i]};
    // Low bits are t mod RADIX, the arithmetic shift gives floor(t / RADIX).
    assign sum[i*RADIX_BITS +: RADIX_BITS] = {{(RADIX_BITS-LR){1'b0}}, t[LR-1:0]};
    assign carry[i+1] = t[LR +: RADIX_BITS];
  end

  assign cout = carry[NO_OF_DIGITS];

endmodule

// File: rtl/radix4_chunk_add_ctrl.sv
// Adds two NUM_CHUNKS-chunk redundant radix-4 operands through one shared adder, one chunk per cycle.
// Optional RADIX4_CHUNK_CTRL_ACCUM_EN adds an acc input selecting dout as operand A (dout += din2).
module radix4_chunk_add_ctrl
  import radix4_pkg::*;
#(
  parameter int NUM_CHUNKS   = 2,
  parameter int NO_OF_DIGITS = NO_OF_DIGITS_DEF,
  parameter int RADIX_BITS   = RADIX_BITS_DEF,
  parameter int RADIX        = RADIX_DEF
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [RADIX_BITS-1:0]                      cin,
  input  logic [NUM_CHUNKS*NO_OF_DIGITS*RADIX_BITS-1:0] din1,
  input  logic [NUM_CHUNKS*NO_OF_DIGITS*RADIX_BITS-1:0] din2,
`ifdef RADIX4_CHUNK_CTRL_ACCUM_EN
  input  logic                                       acc,
`endif
  output logic                                       ready,
  output logic                                       busy,
  output logic                                       done,
  output logic [$clog2(NUM_CHUNKS):0]                chunk_idx,
  output logic [NUM_CHUNKS*NO_OF_DIGITS*RADIX_BITS-1:0] dout,
  output logic [RADIX_BITS-1:0]                      cout
);

  localparam int CW = NO_OF_DIGITS * RADIX_BITS;
  localparam int IW = $clog2(NUM_CHUNKS) + 1;

  state_e                          state_q, state_d;
  logic [NUM_CHUNKS-1:0][CW-1:0]   opa_q, opa_d, opb_q, opb_d, dout_q, dout_d;
  logic [NUM_CHUNKS-1:0][CW-1:0]   src_a;
  logic [RADIX_BITS-1:0]           carry_q, carry_d, cout_q, cout_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic [CW-1:0]                   add_a, add_b, add_sum;
  logic [RADIX_BITS-1:0]           add_cout;
  logic                            accept;
  logic                            last;

`ifdef RADIX4_CHUNK_CTRL_ACCUM_EN
  assign src_a = acc ? dout_q : din1;
`else
  assign src_a = din1;
`endif

  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (idx_q == IW'(k)) begin
        add_a = opa_q[k];
        add_b = opb_q[k];
      end
    end
  end

  radix4adder_new #(
    .NO_OF_DIGITS (NO_OF_DIGITS),
    .RADIX_BITS   (RADIX_BITS),
    .RADIX        (RADIX)
  ) u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign last = (idx_q == IW'(NUM_CHUNKS - 1));

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    dout_d  = dout_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: accept = start;
      RUN: begin
        for (int k = 0; k < NUM_CHUNKS; k++) begin
          if (idx_q == IW'(k)) dout_d[k] = add_sum;
        end
        carry_d = add_cout;
        idx_d   = idx_q + IW'(1);
        if (last) begin
          cout_d  = add_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        accept  = start;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Operand A is taken before dout is cleared so accumulate sees the previous sum.
    if (accept) begin
      state_d = RUN;
      opa_d   = src_a;
      opb_d   = din2;
      carry_d = cin;
      idx_d   = '0;
      dout_d  = '0;
      cout_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      dout_q  <= '0;
      carry_q <= '0;
      cout_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      dout_q  <= dout_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  assign ready     = (state_q != RUN);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign chunk_idx = idx_q;
  assign dout      = dout_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_radix4_chunk_add_ctrl.sv
// Randomized and directed bench for radix4_chunk_add_ctrl against a value-level reference model.
module tb_radix4_chunk_add_ctrl;
  import radix4_pkg::*;

  localparam int NC = 2;
  localparam int ND = 4;
  localparam int RB = 3;
  localparam int DW = NC * ND * RB;
  localparam longint TOPW = longint'(1) << (2 * NC * ND);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [RB-1:0] cin = '0;
  logic [DW-1:0] din1 = '0;
  logic [DW-1:0] din2 = '0;
  logic          acc = 1'b0;
  logic          ready, busy, done;
  logic [$clog2(NC):0] chunk_idx;
  logic [DW-1:0] dout;
  logic [RB-1:0] cout;

  radix4_chunk_add_ctrl #(.NUM_CHUNKS(NC), .NO_OF_DIGITS(ND), .RADIX_BITS(RB), .RADIX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cin       (cin),
    .din1      (din1),
    .din2      (din2),
`ifdef RADIX4_CHUNK_CTRL_ACCUM_EN
    .acc       (acc),
`endif
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .chunk_idx (chunk_idx),
    .dout      (dout),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  int     ntot = 0;
  int     npass = 0;
  // Reference model: RUN cycles left, done flag, chunk counter, pending/held result value.
  int     m_rem = 0;
  bit     m_done = 0;
  int     m_idx = 0;
  longint m_pend = 0;
  longint m_res = 0;
  bit     last_done;
  longint last_val;
  longint last_cval;

  function automatic longint vval(input logic [DW-1:0] v);
    return digits_value(64'(v), NC * ND, RB);
  endfunction

  function automatic longint cval(input logic [RB-1:0] v);
    return digits_value(64'(v), 1, RB);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_step();
    longint a_val;
    a_val = acc ? m_res : vval(din1);
    if (rst) begin
      m_rem = 0; m_done = 0; m_idx = 0; m_res = 0;
    end else if (m_rem > 0) begin
      m_rem--; m_idx++;
      if (m_rem == 0) begin m_done = 1; m_res = m_pend; end
    end else if (start) begin
      m_pend = a_val + vval(din2) + cval(cin);
      m_rem = NC; m_idx = 0; m_done = 0; m_res = 0;
    end else begin
      m_done = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    chk("ready", longint'(ready), longint'(m_rem == 0));
    chk("busy", longint'(busy), longint'(m_rem > 0));
    chk("done", longint'(done), longint'(m_done));
    chk("chunk_idx", longint'(chunk_idx), longint'(m_idx));
    last_done = done;
    last_cval = cval(cout);
    last_val  = vval(dout) + last_cval * TOPW;
    if (m_rem == 0) chk("result_value", last_val, m_res);
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [RB-1:0] c,
                    output int lat, output longint v);
    din1 = a; din2 = b; cin = c; start = 1'b1;
    cycle();
    start = 1'b0;
    lat = -1; v = 0;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (last_done) begin lat = k; v = last_val; break; end
    end
  endtask

  initial begin
    int     lat;
    longint v;
    int     dcnt;
    int     dsum;

    rst = 1'b1;
    @(posedge clk); #1;
    model_step();
    cycle();
    chk("rst_dout", longint'(dout), 0);
    chk("rst_cout", longint'(cout), 0);
    chk("rst_idx", longint'(chunk_idx), 0);
    rst = 1'b0;
    cycle();

    op(24'h249249, 24'h0, 3'b000, lat, v);
    chk("all_ones_latency", lat, 3);
    chk("all_ones_value", v, 21845);
    chk("all_ones_cout", last_cval, 0);

    op(24'h6DB6DB, 24'h000001, 3'b000, lat, v);
    chk("carry_chain_value", v, 65536);

    op(24'h0, 24'h0, 3'b111, lat, v);
    chk("cin_neg_value", v, -1);

    // Start held high: accepted in cycles 0, 3, 6 (and 9), done in 3, 6, 9.
    dcnt = 0; dsum = 0;
    start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      din1 = DW'($urandom); din2 = DW'($urandom); cin = RB'($urandom);
      cycle();
      if (last_done) begin dcnt++; dsum += k; end
    end
    chk("b2b_done_count", dcnt, 3);
    chk("b2b_done_cycles", dsum, 18);
    start = 1'b0;
    for (int k = 0; k < 4; k++) cycle();

    // Reset during the first RUN cycle discards the partial result.
    din1 = DW'($urandom); din2 = DW'($urandom); cin = RB'($urandom); start = 1'b1;
    cycle();
    start = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (last_done) dcnt++;
    end
    chk("midrun_rst_no_done", dcnt, 0);
    chk("midrun_rst_dout", longint'(dout), 0);
    chk("midrun_rst_cout", longint'(cout), 0);
    op(DW'($urandom), DW'($urandom), RB'($urandom), lat, v);
    chk("after_rst_latency", lat, 3);

    for (int k = 0; k < 400; k++) begin
      rst   = ($urandom_range(0, 40) == 0);
      start = $urandom_range(0, 1) == 1;
      din1  = DW'($urandom);
      din2  = DW'($urandom);
      cin   = RB'($urandom);
      cycle();
    end
    rst = 1'b0; start = 1'b0;
    for (int k = 0; k < 5; k++) cycle();

`ifdef RADIX4_CHUNK_CTRL_ACCUM_EN
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    acc = 1'b1;
    for (int k = 0; k < 3; k++) op(DW'($urandom), 24'h000009, 3'b000, lat, v);
    chk("accum_value", v, 15);
    acc = 1'b0;
    cycle();
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
